seq_mult_ctrl: RTL and testbench

Sequencing controller for a radix-2 shift-and-add multiplier datapath. It accepts operand pairs over a valid/ready handshake and steps the datapath through WIDTH add cycles, one multiplier bit per cycle. It presents the product over a second valid/ready handshake, so upstream and downstream logic never see raw datapath timing. It is the block that feeds and drains the sequential multiplier in the arithmetic subsystem.

---
 rtl/seq_mult_pkg.sv | 23 ++
 rtl/seq_mult_ctrl_shift_add_dp.sv | 72 +++++++
 rtl/seq_mult_ctrl.sv | 96 +++++++++
 tb/tb_seq_mult_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding, default operand width and counter sizing.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_mult_ctrl_shift_add_dp.sv
// Shift-and-add datapath: operand registers, bit counter and accumulator.
// Consumes one multiplier bit per step; the controller decides when to load/step/clear.
module shift_add_dp
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               clr,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] acc
);

  localparam int CNT_W = clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;

  logic [PW-1:0]    a_ext_q, a_ext_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pp [WIDTH];

  // Partial product for each bit position; the counter selects which one to add.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign pp[gi] = b_q[gi] ? (a_ext_q << gi) : '0;
    end
  endgenerate

  always_comb begin
    a_ext_d = a_ext_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load) begin
      a_ext_d = {{WIDTH{1'b0}}, a};
      b_d     = b;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (step) begin
      acc_d = acc_q + pp[cnt_q];
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_ext_q <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      a_ext_q <= a_ext_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(WIDTH - 1));
  assign acc  = acc_q;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Handshake wrapper and sequencing FSM for the shift-and-add multiplier.
// Accepts operands on an input valid/ready port and returns the product on an output one.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);

  state_t state_q;
  logic   in_ready_q;
  logic   busy_q;
  logic   out_valid_q;

  logic               dp_load;
  logic               dp_step;
  logic               dp_clr;
  logic               dp_last;
  logic [2*WIDTH-1:0] dp_acc;

  assign dp_load = (state_q == ST_IDLE) && in_valid && in_ready_q;
  assign dp_step = (state_q == ST_CALC);
  assign dp_clr  = out_valid_q && out_ready;

  shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (dp_load),
    .step (dp_step),
    .clr  (dp_clr),
    .a    (in_a),
    .b    (in_b),
    .last (dp_last),
    .acc  (dp_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dp_load) begin
            state_q    <= ST_CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_CALC: begin
          if (dp_last) begin
            state_q     <= ST_HOLD;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  // Partial sums are masked so only a finished product is ever visible.
  assign out_prod  = out_valid_q ? dp_acc : '0;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed testbench for seq_mult_ctrl with WIDTH=4 and hand-computed products.
module tb_seq_mult_ctrl;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_prod;
  logic           busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operand pair and measures cycles from accept to out_valid; no checking here.
  task automatic transact(input logic [W-1:0] a, input logic [W-1:0] b, input logic keep_valid,
                          output int lat, output int busy_cycles, output logic stale,
                          output logic [2*W-1:0] prod, output int acc_cyc);
    int guard;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    acc_cyc = cyc;
    tick();
    if (!keep_valid) in_valid = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    stale       = 1'b0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cycles++;
      if (out_prod !== '0) stale = 1'b1;
      tick();
      lat++;
    end
    prod = out_prod;
    $display("[TB] op a=%0d b=%0d prod=%0d latency=%0d", a, b, prod, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    tick();
    tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (out_prod !== 8'd0) begin fails++; $display("FAIL reset_out_prod: got %0d expected 0", out_prod); end
    rst = 1'b0;
    tick();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    int lat, bc, ac;
    logic st;
    logic [2*W-1:0] p;
    out_ready = 1'b1;
    transact(4'd3, 4'd2, 1'b0, lat, bc, st, p, ac);
    tests++; if (lat !== 4) begin fails++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    tests++; if (bc !== 4) begin fails++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
    tests++; if (st !== 1'b0) begin fails++; $display("FAIL basic_stale_prod: got %b expected 0", st); end
    tests++; if (p !== 8'd6) begin fails++; $display("FAIL basic_prod: got %0d expected 6", p); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain_valid: got %b expected 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_drain_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_max();
    int lat, bc, ac;
    logic st;
    logic [2*W-1:0] p;
    out_ready = 1'b1;
    transact(4'd15, 4'd15, 1'b0, lat, bc, st, p, ac);
    tests++; if (p !== 8'hE1) begin fails++; $display("FAIL max_prod: got %0d expected 225", p); end
    tests++; if (lat !== 4) begin fails++; $display("FAIL max_latency: got %0d expected 4", lat); end
    tick();
    transact(4'd0, 4'd13, 1'b0, lat, bc, st, p, ac);
    tests++; if (p !== 8'd0) begin fails++; $display("FAIL zero_prod: got %0d expected 0", p); end
    tests++; if (lat !== 4) begin fails++; $display("FAIL zero_latency: got %0d expected 4", lat); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat, bc, ac;
    logic st;
    logic [2*W-1:0] p;
    out_ready = 1'b0;
    transact(4'd5, 4'd7, 1'b0, lat, bc, st, p, ac);
    tests++; if (p !== 8'd35) begin fails++; $display("FAIL bp_prod: got %0d expected 35", p); end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_prod !== 8'd35) begin
        fails++;
        $display("FAIL bp_hold_%0d: got valid=%b prod=%0d expected valid=1 prod=35", i, out_valid, out_prod);
      end
    end
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_ignored_input();
    out_ready = 1'b1;
    in_a = 4'd9; in_b = 4'd6; in_valid = 1'b1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ign_ready: got %b expected 1", in_ready); end
    tick();
    for (int i = 0; i < W; i++) begin
      in_a = W'($urandom);
      in_b = W'($urandom);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ign_busy_%0d: got %b expected 1", i, busy); end
      tick();
    end
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ign_valid: got %b expected 1", out_valid); end
    tests++; if (out_prod !== 8'd54) begin fails++; $display("FAIL ign_prod: got %0d expected 54", out_prod); end
    $display("[TB] op a=9 b=6 (inputs toggled in CALC) prod=%0d", out_prod);
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, bc, ac;
    logic st, seen;
    logic [2*W-1:0] p;
    out_ready = 1'b1;
    in_a = 4'd11; in_b = 4'd13; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rmid_in_ready: got %b expected 0", in_ready); end
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rmid_no_valid: got %b expected 0", seen); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready: got %b expected 1", in_ready); end
    transact(4'd2, 4'd2, 1'b0, lat, bc, st, p, ac);
    tests++; if (p !== 8'd4) begin fails++; $display("FAIL rmid_prod: got %0d expected 4", p); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   av [4] = '{4'd1, 4'd2, 4'd15, 4'd8};
    logic [W-1:0]   bv [4] = '{4'd1, 4'd3, 4'd1, 4'd8};
    logic [2*W-1:0] ev [4] = '{8'd1, 8'd6, 8'd15, 8'd64};
    int acc_at [4];
    int lat, bc;
    logic st;
    logic [2*W-1:0] p;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      transact(av[i], bv[i], 1'b1, lat, bc, st, p, acc_at[i]);
      tests++;
      if (p !== ev[i]) begin fails++; $display("FAIL b2b_prod_%0d: got %0d expected %0d", i, p, ev[i]); end
      if (i > 0) begin
        tests++;
        if (acc_at[i] - acc_at[i-1] !== 6) begin
          fails++;
          $display("FAIL b2b_spacing_%0d: got %0d expected 6", i, acc_at[i] - acc_at[i-1]);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_ignored_input();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
